wb_master: RTL and testbench

WB_MASTER -- requirements
Module: wb_master

---
 rtl/wb_master.sv | 111 +++++++++++
 tb/tb_wb_master.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master.sv
// wb_master: single-outstanding Wishbone classic bus master.
//
// Accepts one command on a valid/ready request port and runs it as a single
// Wishbone cycle. It then returns the result on a valid/ready response port.
// A cycle with no ack_i is aborted after TIMEOUT_CYCLES strobe cycles, and
// the response reports resp_err=1.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           command handshake (req_ready = state is idle)
//   req_we/req_adr/req_dat/req_sel command fields
//   resp_valid/resp_ready         response handshake
//   resp_dat/resp_err             read data (0 for writes/aborts), abort flag
//   adr_o/dat_o/we_o/sel_o        Wishbone outputs, latched at acceptance
//   cyc_o/stb_o                   Wishbone cycle/strobe
//   dat_i/ack_i                   Wishbone slave return
module wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  input  logic [3:0]  req_sel,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_dat,
  output logic        resp_err,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic        ack_i
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  // The counter holds the number of strobe cycles already elapsed without an
  // ack. The abort fires on the edge that ends strobe cycle TIMEOUT_CYCLES.
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  state_e     state;
  logic [7:0] cnt;

  assign req_ready = (state == StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      cnt        <= 8'd0;
      adr_o      <= 32'd0;
      dat_o      <= 32'd0;
      we_o       <= 1'b0;
      sel_o      <= 4'd0;
      cyc_o      <= 1'b0;
      stb_o      <= 1'b0;
      resp_valid <= 1'b0;
      resp_dat   <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (req_valid) begin
            adr_o <= req_adr;
            dat_o <= req_dat;
            we_o  <= req_we;
            sel_o <= req_sel;
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            cnt   <= 8'd0;
            state <= StBus;
          end
        end
        StBus: begin
          // The ack is checked first, so an ack on the final cycle wins over the timeout.
          if (ack_i) begin
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            resp_dat   <= we_o ? 32'd0 : dat_i;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= StResp;
          end else if (cnt == CntLast) begin
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            resp_dat   <= 32'd0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= StResp;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master.sv
// Directed testbench for wb_master. Inputs are driven and outputs are sampled
// on the falling clock edge.
module tb_wb_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_adr;
  logic [31:0] req_dat;
  logic [3:0]  req_sel;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_dat;
  logic        resp_err;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        we_o;
  logic [3:0]  sel_o;
  logic        cyc_o;
  logic        stb_o;
  logic        ack_i;

  int checks;
  int failures;

  wb_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_adr    (req_adr),
    .req_dat    (req_dat),
    .req_sel    (req_sel),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_dat   (resp_dat),
    .resp_err   (resp_err),
    .adr_o      (adr_o),
    .dat_o      (dat_o),
    .dat_i      (dat_i),
    .we_o       (we_o),
    .sel_o      (sel_o),
    .cyc_o      (cyc_o),
    .stb_o      (stb_o),
    .ack_i      (ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({cyc_o, stb_o, we_o, sel_o, resp_valid, resp_err} !== 9'd0) begin
      failures++;
      $display("FAIL reset_ctrl got cyc=%b stb=%b we=%b sel=%h rv=%b err=%b want all 0",
               cyc_o, stb_o, we_o, sel_o, resp_valid, resp_err);
    end
    checks++;
    if ({adr_o, dat_o, resp_dat} !== 96'd0) begin
      failures++;
      $display("FAIL reset_data got adr=%h dat=%h rdat=%h want 0", adr_o, dat_o, resp_dat);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_req_ready got %b want 1", req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    // An ack seen while idle must not change any state.
    ack_i = 1'b1;
    dat_i = 32'h1234_5678;
    step();
    ack_i = 1'b0;
    checks++;
    if ({cyc_o, resp_valid, req_ready} !== 3'b001) begin
      failures++;
      $display("FAIL idle_ack got cyc=%b rv=%b rdy=%b want 0 0 1", cyc_o, resp_valid, req_ready);
    end
  endtask

  task automatic test_read();
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h4; req_sel = 4'hF; req_dat = 32'h0;
    step();
    req_valid = 1'b0;
    checks++;
    if ({cyc_o, stb_o, we_o, sel_o, adr_o, req_ready} !== {3'b110, 4'hF, 32'h4, 1'b0}) begin
      failures++;
      $display("FAIL read_bus got cyc=%b stb=%b we=%b sel=%h adr=%h rdy=%b want 1 1 0 f 4 0",
               cyc_o, stb_o, we_o, sel_o, adr_o, req_ready);
    end
    ack_i = 1'b1; dat_i = 32'h1;
    step();
    ack_i = 1'b0; dat_i = 32'h0;
    checks++;
    if ({cyc_o, stb_o, resp_valid, resp_err, resp_dat} !== {4'b0010, 32'h1}) begin
      failures++;
      $display("FAIL read_resp got cyc=%b stb=%b rv=%b err=%b dat=%h want 0 0 1 0 1",
               cyc_o, stb_o, resp_valid, resp_err, resp_dat);
    end
    drain();
    checks++;
    if ({resp_valid, req_ready, resp_dat} !== {2'b01, 32'h1}) begin
      failures++;
      $display("FAIL read_done got rv=%b rdy=%b dat=%h want 0 1 1", resp_valid, req_ready, resp_dat);
    end
  endtask

  task automatic test_write();
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h2; req_dat = 32'h1; req_sel = 4'h1;
    step();
    req_valid = 1'b0;
    checks++;
    if ({adr_o, dat_o, we_o, sel_o, cyc_o, stb_o} !== {32'h2, 32'h1, 1'b1, 4'h1, 2'b11}) begin
      failures++;
      $display("FAIL write_bus got adr=%h dat=%h we=%b sel=%h cyc=%b stb=%b want 2 1 1 1 1 1",
               adr_o, dat_o, we_o, sel_o, cyc_o, stb_o);
    end
    ack_i = 1'b1; dat_i = 32'hFFFF_FFFF;
    step();
    ack_i = 1'b0;
    checks++;
    if ({resp_valid, resp_err, resp_dat, cyc_o} !== {2'b10, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL write_resp got rv=%b err=%b dat=%h cyc=%b want 1 0 0 0",
               resp_valid, resp_err, resp_dat, cyc_o);
    end
    drain();
  endtask

  task automatic test_timeout();
    int n;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h100; req_sel = 4'h3;
    step();
    // Request changes during the bus cycle must not reach the bus outputs.
    req_adr = 32'hBAD0; req_sel = 4'hC; req_we = 1'b1;
    dat_i = 32'hDEAD_BEEF;
    n = 0;
    while (stb_o === 1'b1 && n < 40) begin
      n++;
      step();
    end
    req_valid = 1'b0;
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL timeout_len got %0d stb cycles want 16", n);
    end
    checks++;
    if ({resp_valid, resp_err, resp_dat} !== {2'b11, 32'h0}) begin
      failures++;
      $display("FAIL timeout_resp got rv=%b err=%b dat=%h want 1 1 0", resp_valid, resp_err, resp_dat);
    end
    checks++;
    if ({adr_o, sel_o, we_o} !== {32'h100, 4'h3, 1'b0}) begin
      failures++;
      $display("FAIL timeout_hold got adr=%h sel=%h we=%b want 100 3 0", adr_o, sel_o, we_o);
    end
    drain();
  endtask

  task automatic test_ack_last();
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h20; req_sel = 4'hF;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    checks++;
    if ({stb_o, resp_valid} !== 2'b10) begin
      failures++;
      $display("FAIL ack_last_pre got stb=%b rv=%b want 1 0", stb_o, resp_valid);
    end
    ack_i = 1'b1; dat_i = 32'hA5;
    step();
    ack_i = 1'b0;
    checks++;
    if ({resp_valid, resp_err, resp_dat} !== {2'b10, 32'hA5}) begin
      failures++;
      $display("FAIL ack_last got rv=%b err=%b dat=%h want 1 0 a5", resp_valid, resp_err, resp_dat);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int bad;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h40; req_sel = 4'hF;
    step();
    req_valid = 1'b0;
    ack_i = 1'b1; dat_i = 32'h5A5A_0001;
    step();
    ack_i = 1'b0;
    req_valid = 1'b1; req_adr = 32'h80;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        ack_i = 1'b1; dat_i = 32'h1111_2222;
      end else begin
        ack_i = 1'b0;
      end
      if ({resp_valid, resp_dat, req_ready, cyc_o, adr_o} !== {1'b1, 32'h5A5A_0001, 2'b00, 32'h40})
        bad++;
      step();
    end
    ack_i = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL backpressure_hold got %0d unstable cycles want 0", bad);
    end
    checks++;
    if ({resp_valid, resp_dat} !== {1'b1, 32'h5A5A_0001}) begin
      failures++;
      $display("FAIL backpressure_end got rv=%b dat=%h want 1 5a5a0001", resp_valid, resp_dat);
    end
    drain();
    checks++;
    if ({resp_valid, req_ready, cyc_o} !== 3'b010) begin
      failures++;
      $display("FAIL backpressure_idle got rv=%b rdy=%b cyc=%b want 0 1 0",
               resp_valid, req_ready, cyc_o);
    end
  endtask

  task automatic test_reset_mid_bus();
    int bad;
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'hC0; req_dat = 32'h99; req_sel = 4'hF;
    step();
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cyc_o, stb_o, resp_valid, adr_o} !== {3'b000, 32'h0}) begin
      failures++;
      $display("FAIL async_reset got cyc=%b stb=%b rv=%b adr=%h want 0 0 0 0",
               cyc_o, stb_o, resp_valid, adr_o);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (resp_valid !== 1'b0 || cyc_o !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_no_resp got %0d bad cycles want 0", bad);
    end
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h8; req_sel = 4'hF;
    step();
    req_valid = 1'b0;
    checks++;
    if ({cyc_o, stb_o, adr_o, we_o} !== {2'b11, 32'h8, 1'b0}) begin
      failures++;
      $display("FAIL post_reset_bus got cyc=%b stb=%b adr=%h we=%b want 1 1 8 0",
               cyc_o, stb_o, adr_o, we_o);
    end
    ack_i = 1'b1; dat_i = 32'h77;
    step();
    ack_i = 1'b0;
    checks++;
    if ({resp_valid, resp_err, resp_dat} !== {2'b10, 32'h77}) begin
      failures++;
      $display("FAIL post_reset_read got rv=%b err=%b dat=%h want 1 0 77",
               resp_valid, resp_err, resp_dat);
    end
    drain();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_adr = 32'h0; req_dat = 32'h0; req_sel = 4'h0;
    resp_ready = 1'b0; dat_i = 32'h0; ack_i = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_ack_last();
    test_backpressure();
    test_reset_mid_bus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
